weight_fifo_tiled: RTL
======================

Name: weight_fifo_tiled

Overview:
- Parametrised successor of the single-size weight FIFO that feeds weight rows into the systolic array.
- Circular buffer with pointers and an occupancy counter; no shift register.
- Generic lane count, lane width and depth.
- Tracks weight tiles (ROWS_PER_TILE rows each) and flags the last row of each tile to the array loader; sits between the weight DMA/fetch unit and the array weight-load path.

Parameters:
- LANES, 32, array columns (lanes per row).
- DATA_W, 8, bits per lane.
- ROWS_PER_TILE, 32, rows forming one weight tile.
- DEPTH, 128, rows stored; power of two, integer multiple of ROWS_PER_TILE, at least 2*ROWS_PER_TILE.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- write_en_i  in  1  producer wants to write.
- sending_data_i  in  1  data_i carries a valid row this cycle.
- data_i  in  LANES x DATA_W  incoming weight row.
- request_data_o  out  1  FIFO can accept a row this cycle.
- read_en_i  in  1  consumer pops head.
- valid_o  out  1  data_o holds a popped row.
- data_o  out  LANES x DATA_W  popped row.
- tile_last_o  out  1  qualifies valid_o: last row of a tile.
- count_o  out  CNT_W  rows held (not yet freed).
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  no readable row.

Behaviour:
- Reset (rst_i low, async):
  - wr_ptr, rd_ptr, base_ptr, row_cnt = 0; count = 0.
  - valid_o = 0, tile_last_o = 0, data_o = 0; full_o = 0, empty_o = 1.
  - Reset mid-burst discards all contents; the first post-reset write lands at entry 0.
- Write:
  - request_data_o = write_en_i & ~full_o (combinational, no dependence on read_en_i).
  - push = write_en_i & sending_data_i & ~full_o.
  - On push: mem[wr_ptr] <= data_i, wr_ptr <= wr_ptr+1 mod DEPTH.
  - sending_data_i while full_o is dropped silently; the producer must honour request_data_o.
- Readable rows: avail = wr_ptr - rd_ptr (mod DEPTH, with a wrap flag to tell full from empty). empty_o = (avail == 0).
- Read:
  - pop = read_en_i & ~empty_o.
  - Latency 1: on the next edge, data_o <= mem[rd_ptr], valid_o <= 1, rd_ptr <= rd_ptr+1.
  - If read_en_i & empty_o, then valid_o <= 0 and data_o holds its previous value.
  - If read_en_i = 0, then valid_o <= 0.
- Tile tracking:
  - row_cnt counts pops modulo ROWS_PER_TILE.
  - tile_last_o <= pop & (row_cnt == ROWS_PER_TILE-1), aligned with valid_o.
- Freeing (macro off): each pop frees its entry; base_ptr follows rd_ptr.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: unchanged.
- Simultaneous push and pop:
  - Allowed when count == DEPTH-1 or any non-full level.
  - When full, push is blocked even if pop is asserted; space appears next cycle.
  - Push into an empty FIFO is readable no earlier than the next cycle; no combinational bypass.
- Wrap-around: all pointers wrap mod DEPTH without a bubble.
- full_o and empty_o are derived from registered state only.

Optional Feature:
- Macro WEIGHT_FIFO_REPLAY_EN adds input replay_i (1 bit). Freeing becomes per tile:
  - On the pop that asserts tile_last_o:
    - If replay_i = 1: rd_ptr <= base_ptr; count unchanged; the same tile is re-issued starting next cycle (reuse across input batches).
    - If replay_i = 0: base_ptr <= base_ptr + ROWS_PER_TILE; count -= ROWS_PER_TILE, plus 1 if push in the same cycle.
  - count_o and full_o then include rows already read but not yet freed.
- Without the macro: the port is absent and freeing is per pop, as above.

Test Plan:
- Reset, then write 128 rows (row k, lane j = k+j mod 256) with read_en_i = 0 → full_o = 1, request_data_o = 0, count_o = 128; the 129th row is dropped.
- Read 128 rows back-to-back → valid_o high for 128 cycles starting 1 cycle after the first read_en_i; data matches in order; tile_last_o on reads 32, 64, 96, 128; then empty_o = 1.
- Read on empty → valid_o = 0 and data_o unchanged; push 1 row and read next cycle → valid_o = 1 with that row.
- Write and read simultaneously for 300 cycles at half occupancy → count_o constant, pointers wrap twice, no data loss.
- Assert rst_i low mid-write at count_o = 57 → all outputs at reset values immediately (asynchronously); a subsequent write/read returns the new row.
- With WEIGHT_FIFO_REPLAY_EN: load 2 tiles, hold replay_i = 1 at the first tile_last_o → the next 32 reads repeat tile 0 and count_o stays 64; replay_i = 0 at the second tile_last_o → tile 1 follows and count_o drops to 32.

Source files
------------

// File: rtl/weight_fifo_tiled_if.sv
// Handshake/bus bundle between weight fetch, weight_fifo_tiled and the array loader.
// WEIGHT_FIFO_REPLAY_EN adds the replay_i tile-reuse input.
interface weight_fifo_tiled_if #(
    parameter int unsigned LANES  = 32,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic                      write_en_i;
    logic                      sending_data_i;
    logic [LANES*DATA_W-1:0]   data_i;
    logic                      request_data_o;
    logic                      read_en_i;
    logic                      valid_o;
    logic [LANES*DATA_W-1:0]   data_o;
    logic                      tile_last_o;
    logic [CNT_W-1:0]          count_o;
    logic                      full_o;
    logic                      empty_o;
`ifdef WEIGHT_FIFO_REPLAY_EN
    logic                      replay_i;

    modport slave (
        input  write_en_i, sending_data_i, data_i, read_en_i, replay_i,
        output request_data_o, valid_o, data_o, tile_last_o, count_o, full_o, empty_o
    );
    modport master (
        output write_en_i, sending_data_i, data_i, read_en_i, replay_i,
        input  request_data_o, valid_o, data_o, tile_last_o, count_o, full_o, empty_o
    );
`else
    modport slave (
        input  write_en_i, sending_data_i, data_i, read_en_i,
        output request_data_o, valid_o, data_o, tile_last_o, count_o, full_o, empty_o
    );
    modport master (
        output write_en_i, sending_data_i, data_i, read_en_i,
        input  request_data_o, valid_o, data_o, tile_last_o, count_o, full_o, empty_o
    );
`endif
endinterface

// File: rtl/weight_fifo_tiled.sv
// Circular weight-row FIFO with tile tracking; WEIGHT_FIFO_REPLAY_EN switches
// entry freeing from per-pop to per-tile with optional tile replay.
module weight_fifo_tiled #(
    parameter int unsigned LANES         = 32,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ROWS_PER_TILE = 32,
    parameter int unsigned DEPTH         = 128,
    parameter int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    weight_fifo_tiled_if.slave bus
);
    localparam int unsigned ROW_W = LANES * DATA_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned PW    = PTR_W + 1;
    localparam int unsigned RC_W  = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

    logic [ROW_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so wr == rd means empty, not full.
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    base_ptr_q, base_ptr_d;
    logic [RC_W-1:0]  row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             tile_last_q, tile_last_d;
    logic [ROW_W-1:0] data_q, data_d;

    logic [PW-1:0]    avail;
    logic             full, empty, push, pop, tile_end;

    assign avail    = wr_ptr_q - rd_ptr_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (avail == '0);
    assign push     = bus.write_en_i & bus.sending_data_i & ~full;
    assign pop      = bus.read_en_i & ~empty;
    assign tile_end = pop & (row_cnt_q == RC_W'(ROWS_PER_TILE - 1));

    // Next-state for pointers, occupancy, tile counter and the output row.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        base_ptr_d  = base_ptr_q;
        row_cnt_d   = row_cnt_q;
        count_d     = count_q;
        valid_d     = pop;
        tile_last_d = tile_end;
        data_d      = data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            data_d    = mem[rd_ptr_q[PTR_W-1:0]];
            rd_ptr_d  = rd_ptr_q + PW'(1);
            row_cnt_d = tile_end ? '0 : row_cnt_q + RC_W'(1);
        end
`ifdef WEIGHT_FIFO_REPLAY_EN
        // Rows stay allocated until their whole tile is released.
        count_d = count_q + CNT_W'(push);
        if (tile_end) begin
            if (bus.replay_i) begin
                rd_ptr_d = base_ptr_q;
            end else begin
                base_ptr_d = base_ptr_q + PW'(ROWS_PER_TILE);
                count_d    = count_q + CNT_W'(push) - CNT_W'(ROWS_PER_TILE);
            end
        end
`else
        base_ptr_d = rd_ptr_d;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            base_ptr_q  <= '0;
            row_cnt_q   <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            tile_last_q <= 1'b0;
            data_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            base_ptr_q  <= base_ptr_d;
            row_cnt_q   <= row_cnt_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            tile_last_q <= tile_last_d;
            data_q      <= data_d;
        end
    end

    // Storage array carries no reset; contents are only visible through the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= bus.data_i;
        end
    end

    assign bus.request_data_o = bus.write_en_i & ~full;
    assign bus.valid_o        = valid_q;
    assign bus.data_o         = data_q;
    assign bus.tile_last_o    = tile_last_q;
    assign bus.count_o        = count_q;
    assign bus.full_o         = full;
    assign bus.empty_o        = empty;

endmodule
